// File: rtl/dmem_lsu.sv
// dmem_lsu: data-memory load/store unit with programmable wait states.
//
// Byte/half/word loads and stores, little-endian, sign or zero extension on loads.
// Every access runs through a req/ready handshake. A misaligned access completes
// one cycle after accept with err=1 and leaves memory untouched.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (memory contents are kept)
//   req    access request, held high by the core until ready
//   we     1 = store, 0 = load
//   size   00 byte, 01 half, 10 word, 11 reserved (always misaligned)
//   unsgn  zero-extend loads when 1, sign-extend when 0
//   addr   byte address; bits above the memory index are ignored (wrap-around)
//   wdata  store data, low byte/half used for byte/half stores
//   rdata  load result, holds until the next completed load or misaligned access
//   ready  one-cycle completion pulse
//   err    with ready: access was misaligned and nothing was done
//   stall  core must hold its pipeline this cycle
module dmem_lsu #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LATENCY  = 2,
    parameter string       INIT_HEX = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        stall
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [3:0]  LatCnt = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             unsgn_q;
    logic [AW+1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             ready_q;
    logic             err_q;

    logic [31:0]      mem [DEPTH];

    // Address bits above the word index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    logic aligned;
    always_comb begin
        aligned = 1'b0;
        unique case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [31:0]   load_val;
    logic [31:0]   wshift;
    logic [3:0]    be;
    logic          mem_we;

    assign idx   = addr_q[AW+1:2];
    assign rword = mem[idx];
    // Alignment guarantees a half sits at addr[1:0] in {0,2}, so one byte-granular
    // shift serves both byte and half lanes.
    assign rshift = rword >> {addr_q[1:0], 3'b000};
    assign wshift = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = rword;
        be       = 4'b1111;
        unique case (size_q)
            2'b00: begin
                load_val = {{24{~unsgn_q & rshift[7]}}, rshift[7:0]};
                be       = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                load_val = {{16{~unsgn_q & rshift[15]}}, rshift[15:0]};
                be       = 4'b0011 << addr_q[1:0];
            end
            default: begin
                load_val = rword;
                be       = 4'b1111;
            end
        endcase
    end

    // Gated by reset so an access aborted at its final edge never writes.
    assign mem_we = ~reset & (state_q == StBusy) & (cnt_q == 4'd0) & we_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            unsgn_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        unsgn_q <= unsgn;
                        addr_q  <= addr[AW+1:0];
                        wdata_q <= wdata;
                        if (aligned) begin
                            state_q <= StBusy;
                            cnt_q   <= LatCnt;
                        end else begin
                            state_q <= StDone;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (!we_q) rdata_q <= load_val;
                        ready_q <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = ((state_q == StIdle) & req) | (state_q == StBusy);

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req2, req0;
    logic        we, unsgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata2, rdata0;
    logic        ready2, ready0, err2, err0, stall2, stall0;

    int total = 0;
    int bad   = 0;

    // Instance with two wait states and one with none; inputs shared, req separate.
    dmem_lsu #(.DEPTH(256), .LATENCY(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .req   (req2),
        .we    (we),
        .size  (size),
        .unsgn (unsgn),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata2),
        .ready (ready2),
        .err   (err2),
        .stall (stall2)
    );

    dmem_lsu #(.DEPTH(256), .LATENCY(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .req   (req0),
        .we    (we),
        .size  (size),
        .unsgn (unsgn),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0),
        .stall (stall0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // One access on the selected instance (sel=1 -> LATENCY=0 instance).
    // lat = cycles after the accept edge until ready; -1 if the budget expired.
    task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e, output int lat,
                          output int stall_cnt);
        logic rdy, stl;
        rd = 32'd0;
        e = 1'b0;
        lat = -1;
        stall_cnt = 0;
        @(negedge clk);
        we = w; size = sz; unsgn = u; addr = a; wdata = d;
        if (sel) req0 = 1'b1; else req2 = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            rdy = sel ? ready0 : ready2;
            stl = sel ? stall0 : stall2;
            if (stl) stall_cnt++;
            if (rdy) begin
                lat = n;
                rd = sel ? rdata0 : rdata2;
                e = sel ? err0 : err2;
                break;
            end
            if (n == 1) begin
                // Registered request must be immune to later input changes.
                we = ~w; size = ~sz; unsgn = ~u; addr = a ^ 32'h0000_0017; wdata = ~d;
            end
        end
        req0 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic run(input string tag, input bit sel, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd;
        logic        e;
        int          lat, sc, exp_lat;
        exp_lat = exp_err ? 1 : (sel ? 2 : 4);
        access(sel, w, sz, u, a, d, rd, e, lat, sc);
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " err"}, {31'd0, e}, {31'd0, exp_err});
        check_eq({tag, " stall cycles"}, 32'(sc), 32'(exp_lat - 1));
        if (!w || exp_err) check_eq({tag, " rdata"}, rd, exp_rd);
    endtask

    initial begin
        reset = 1'b1; req2 = 1'b0; req0 = 1'b0;
        we = 1'b0; size = 2'b00; unsgn = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset ready", {30'd0, ready2, ready0}, 32'd0);
        check_eq("reset err", {30'd0, err2, err0}, 32'd0);
        check_eq("reset stall", {30'd0, stall2, stall0}, 32'd0);
        check_eq("reset rdata2", rdata2, 32'd0);
        check_eq("reset rdata0", rdata0, 32'd0);
        reset = 1'b0;

        run("prep sw 0x30", 0, 1, 2'b10, 0, 32'h30, 32'h5566_7788, 32'h0, 0);

        // T1
        run("T1 sw", 0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        run("T1 lw", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);

        // T2
        run("T2 sw", 0, 1, 2'b10, 0, 32'h10, 32'h80F0_7F01, 32'h0, 0);
        run("T2 lb", 0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 0);
        run("T2 lbu", 0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h0000_0080, 0);
        run("T2 lh", 0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_80F0, 0);
        run("T2 lhu", 0, 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000_7F01, 0);
        run("T2 lb pos", 0, 0, 2'b00, 0, 32'h11, 32'h0, 32'h0000_007F, 0);

        // T3
        run("T3 sw", 0, 1, 2'b10, 0, 32'h20, 32'h1122_3344, 32'h0, 0);
        run("T3 sb", 0, 1, 2'b00, 0, 32'h21, 32'h1234_56AA, 32'h0, 0);
        run("T3 lw after sb", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h1122_AA44, 0);
        run("T3 sh", 0, 1, 2'b01, 0, 32'h22, 32'h9999_BBCC, 32'h0, 0);
        run("T3 lw after sh", 0, 0, 2'b10, 0, 32'h20, 32'h0, 32'hBBCC_AA44, 0);

        // T4
        run("T4 sw 0x0C", 0, 1, 2'b10, 0, 32'h0C, 32'hA5A5_A5A5, 32'h0, 0);
        run("T4 lw 0x10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80F0_7F01, 0);
        run("T4 lw mis", 0, 0, 2'b10, 0, 32'h0E, 32'h0, 32'h0, 1);
        run("T4 sh mis", 0, 1, 2'b01, 0, 32'h11, 32'h0000_FFFF, 32'h0, 1);
        run("T4 size11", 0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
        run("T4 rb 0x0C", 0, 0, 2'b10, 0, 32'h0C, 32'h0, 32'hA5A5_A5A5, 0);
        run("T4 rb 0x10", 0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80F0_7F01, 0);

        // T5: reset during BUSY aborts the store
        @(negedge clk);
        we = 1'b1; size = 2'b10; unsgn = 1'b0; addr = 32'h30; wdata = 32'h1234_5678;
        req2 = 1'b1;
        @(negedge clk);
        check_eq("T5 busy stall", {31'd0, stall2}, 32'd1);
        reset = 1'b1;
        req2 = 1'b0;
        @(negedge clk);
        check_eq("T5 ready after reset", {31'd0, ready2}, 32'd0);
        check_eq("T5 stall after reset", {31'd0, stall2}, 32'd0);
        reset = 1'b0;
        run("T5 lw 0x30", 0, 0, 2'b10, 0, 32'h30, 32'h0, 32'h5566_7788, 0);

        // T6: wrap-around and zero wait states
        run("T6 sw 0x400", 1, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 0);
        run("T6 lw 0x000", 1, 0, 2'b10, 0, 32'h000, 32'h0, 32'hCAFE_F00D, 0);
        run("T6 sw L0", 1, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        run("T6 lw L0", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
        run("T6 lh L0", 1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFF_DEAD, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
